veri_bellegi: RTL and testbench

- Data-memory responder for the single-cycle RV32I core. It serves the core's vb_* load/store interface.
- Reads are combinational and return data in the same cycle, with forwarding from pending stores.
- Stores are posted into a small FIFO write buffer. The buffer drains into a word array that takes YAZMA_GECIKME cycles per write.
- vb_bekle tells the core to hold a store while the buffer is full.

---
 rtl/veri_bellegi_pkg.sv | 21 ++
 rtl/veri_bellegi_if.sv | 20 ++
 rtl/veri_bellegi_tampon.sv | 39 +++
 rtl/veri_bellegi.sv | 121 ++++++++++++
 tb/tb_veri_bellegi.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/veri_bellegi_pkg.sv
// rtl/veri_bellegi_pkg.sv - shared types and width helpers for the data memory responder
package veri_bellegi_pkg;

  typedef enum logic {
    BOS = 1'b0,
    YAZ = 1'b1
  } bosaltma_durum_t;

  localparam int VERI_BIT = 32;

  // Buffer entry layout is {word index, data}.
  function automatic int giris_bit(input int adres_bit);
    return adres_bit + VERI_BIT;
  endfunction

  // MSB of the word-index slice taken from a byte address.
  function automatic int kelime_ust_bit(input int adres_bit);
    return adres_bit + 1;
  endfunction

endpackage

// File: rtl/veri_bellegi_if.sv
// rtl/veri_bellegi_if.sv - core-side load/store interface of the data memory
interface veri_bellegi_if;
  logic        vb_oku_aktif;
  logic        vb_yaz_aktif;
  logic [31:0] vb_adres;
  logic [31:0] vb_yaz_veri;
  logic [31:0] vb_oku_veri;
  logic        vb_bekle;
  logic        vb_hata;

  modport master (
    output vb_oku_aktif, vb_yaz_aktif, vb_adres, vb_yaz_veri,
    input  vb_oku_veri, vb_bekle, vb_hata
  );

  modport slave (
    input  vb_oku_aktif, vb_yaz_aktif, vb_adres, vb_yaz_veri,
    output vb_oku_veri, vb_bekle, vb_hata
  );
endinterface

// File: rtl/veri_bellegi_tampon.sv
// rtl/veri_bellegi_tampon.sv - posted-store FIFO with every entry visible for forwarding
module yazma_tamponu #(
  parameter int DERINLIK = 4,
  parameter int GENISLIK = 42
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        push,
  input  logic [GENISLIK-1:0]         push_veri,
  input  logic                        pop,
  output logic [GENISLIK-1:0]         girisler [DERINLIK],
  output logic [$clog2(DERINLIK)-1:0] bas,
  output logic [$clog2(DERINLIK):0]   sayac
);

  logic [GENISLIK-1:0]         bellek [DERINLIK];
  logic [$clog2(DERINLIK)-1:0] kuyruk;

  always_ff @(posedge clk) begin
    if (push) bellek[kuyruk] <= push_veri;
  end

  // Pointers wrap naturally because DERINLIK is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bas    <= '0;
      kuyruk <= '0;
      sayac  <= '0;
    end else begin
      if (push) kuyruk <= kuyruk + 1'b1;
      if (pop)  bas    <= bas + 1'b1;
      if (push && !pop)      sayac <= sayac + 1'b1;
      else if (pop && !push) sayac <= sayac - 1'b1;
    end
  end

  assign girisler = bellek;

endmodule

// File: rtl/veri_bellegi.sv
// rtl/veri_bellegi.sv - data memory with posted write buffer; VERI_BELLEGI_HATA_EN enables access-error checks
module veri_bellegi
  import veri_bellegi_pkg::*;
#(
  parameter int ADRES_BIT       = 10,
  parameter int TAMPON_DERINLIK = 4,
  parameter int YAZMA_GECIKME   = 2
) (
  input  logic                               clk,
  input  logic                               rst,
  veri_bellegi_if.slave                      vb,
  output logic [$clog2(TAMPON_DERINLIK):0]   tampon_sayac
);

  localparam int GB  = giris_bit(ADRES_BIT);
  localparam int KU  = kelime_ust_bit(ADRES_BIT);
  localparam int PW  = $clog2(TAMPON_DERINLIK);
  localparam int SCW = $clog2(TAMPON_DERINLIK) + 1;
  localparam int SW  = $clog2(YAZMA_GECIKME + 1);
  localparam logic [SCW-1:0] DOLU    = SCW'(TAMPON_DERINLIK);
  localparam logic [SW-1:0]  GEC_YUK = SW'(YAZMA_GECIKME - 1);

  logic [ADRES_BIT-1:0] kelime;
  logic                 hata;
  logic                 push, pop, yaz_en;
  logic [GB-1:0]        girisler [TAMPON_DERINLIK];
  logic [PW-1:0]        bas, idx;
  logic [SCW-1:0]       kalan;
  logic [31:0]          okunan;
  logic [31:0]          dizi [2**ADRES_BIT];

  bosaltma_durum_t durum, durum_n;
  logic [SW-1:0]   sayici, sayici_n;

  assign kelime = vb.vb_adres[KU:2];

`ifdef VERI_BELLEGI_HATA_EN
  assign hata = (vb.vb_oku_aktif || vb.vb_yaz_aktif) &&
                ((vb.vb_adres[1:0] != 2'b00) ||
                 (vb.vb_adres[31:ADRES_BIT+2] != '0) ||
                 (vb.vb_oku_aktif && vb.vb_yaz_aktif));
`else
  logic unused_adres_bitleri;
  assign unused_adres_bitleri = ^{vb.vb_adres[31:ADRES_BIT+2], vb.vb_adres[1:0]};
  assign hata = 1'b0;
`endif

  // A store alongside a load is dropped; the load still gets served.
  assign push     = vb.vb_yaz_aktif && !vb.vb_oku_aktif && !hata && (tampon_sayac < DOLU);
  assign vb.vb_bekle = vb.vb_yaz_aktif && (tampon_sayac == DOLU);
  assign vb.vb_hata  = hata;

  yazma_tamponu #(
    .DERINLIK (TAMPON_DERINLIK),
    .GENISLIK (GB)
  ) u_tampon (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_veri ({kelime, vb.vb_yaz_veri}),
    .pop       (pop),
    .girisler  (girisler),
    .bas       (bas),
    .sayac     (tampon_sayac)
  );

  // Walk oldest to newest so the newest matching entry wins.
  always_comb begin
    okunan = dizi[kelime];
    idx    = bas;
    for (int i = 0; i < TAMPON_DERINLIK; i++) begin
      idx = bas + PW'(i);
      if ((SCW'(i) < tampon_sayac) && (girisler[idx][GB-1:32] == kelime))
        okunan = girisler[idx][31:0];
    end
  end

  assign vb.vb_oku_veri = (vb.vb_oku_aktif && !hata) ? okunan : 32'h0;

  always_ff @(posedge clk) begin
    if (yaz_en) dizi[girisler[bas][GB-1:32]] <= girisler[bas][31:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      durum  <= BOS;
      sayici <= '0;
    end else begin
      durum  <= durum_n;
      sayici <= sayici_n;
    end
  end

  always_comb begin
    durum_n  = durum;
    sayici_n = sayici;
    pop      = 1'b0;
    yaz_en   = 1'b0;
    kalan    = tampon_sayac - SCW'(1) + SCW'(push);
    case (durum)
      BOS: begin
        if (tampon_sayac != '0) begin
          durum_n  = YAZ;
          sayici_n = GEC_YUK;
        end
      end
      YAZ: begin
        if (sayici == '0) begin
          pop    = 1'b1;
          yaz_en = 1'b1;
          if (kalan != '0) sayici_n = GEC_YUK;
          else             durum_n  = BOS;
        end else begin
          sayici_n = sayici - 1'b1;
        end
      end
      default: durum_n = BOS;
    endcase
  end

endmodule

// File: tb/tb_veri_bellegi.sv
// tb/tb_veri_bellegi.sv - directed self-checking bench for veri_bellegi
module tb_veri_bellegi;
  import veri_bellegi_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] tampon_sayac;

  int test_sayisi = 0;
  int hata_sayisi = 0;
  int max_sayac   = 0;
  logic       bekle_goruldu = 1'b0;
  logic [2:0] sayac_bekle   = '0;
  logic [31:0] d;

  veri_bellegi_if vif ();

  veri_bellegi #(
    .ADRES_BIT       (10),
    .TAMPON_DERINLIK (4),
    .YAZMA_GECIKME   (2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .vb           (vif),
    .tampon_sayac (tampon_sayac)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (int'(tampon_sayac) > max_sayac) max_sayac = int'(tampon_sayac);
  end

  task automatic kontrol(input string etiket, input logic [31:0] gozlenen, input logic [31:0] beklenen);
    test_sayisi++;
    if (gozlenen !== beklenen) begin
      hata_sayisi++;
      $display("FAIL %s: gozlenen=%h beklenen=%h", etiket, gozlenen, beklenen);
    end
  endtask

  task automatic bos(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic yaz(input logic [31:0] a, input logic [31:0] v);
    bit kabul = 1'b0;
    vif.vb_yaz_aktif = 1'b1;
    vif.vb_adres     = a;
    vif.vb_yaz_veri  = v;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (!vif.vb_bekle) begin
        kabul = 1'b1;
        break;
      end
      bekle_goruldu = 1'b1;
      sayac_bekle   = tampon_sayac;
    end
    if (!kabul) kontrol("bekle_zaman_asimi", 32'(vif.vb_bekle), 32'h0);
    @(posedge clk);
    #1;
    vif.vb_yaz_aktif = 1'b0;
  endtask

  task automatic oku(input logic [31:0] a, output logic [31:0] v);
    vif.vb_oku_aktif = 1'b1;
    vif.vb_adres     = a;
    @(negedge clk);
    v = vif.vb_oku_veri;
    vif.vb_oku_aktif = 1'b0;
  endtask

  initial begin
    vif.vb_oku_aktif = 1'b0;
    vif.vb_yaz_aktif = 1'b0;
    vif.vb_adres     = '0;
    vif.vb_yaz_veri  = '0;
    #12;
    kontrol("reset_sayac", 32'(tampon_sayac), 32'd0);
    kontrol("reset_bekle", 32'(vif.vb_bekle), 32'd0);
    kontrol("reset_hata",  32'(vif.vb_hata),  32'd0);
    kontrol("reset_oku",   vif.vb_oku_veri,   32'd0);
    @(negedge clk);
    rst = 1'b1;
    bos(1);

    // Single store: one cycle in BOS, two in YAZ, pop on the third edge.
    yaz(32'h10, 32'hDEADBEEF);
    kontrol("tek_sayac", 32'(tampon_sayac), 32'd1);
    oku(32'h10, d);
    kontrol("tek_tampon_oku", d, 32'hDEADBEEF);
    @(negedge clk); kontrol("tek_sayac_e1", 32'(tampon_sayac), 32'd1);
    @(negedge clk); kontrol("tek_sayac_e2", 32'(tampon_sayac), 32'd1);
    @(negedge clk); kontrol("tek_sayac_e3", 32'(tampon_sayac), 32'd0);
    bos(1);
    oku(32'h10, d);
    kontrol("tek_dizi_oku", d, 32'hDEADBEEF);
    vif.vb_adres = 32'h10;
    #1;
    kontrol("oku_yok_sifir", vif.vb_oku_veri, 32'd0);
    bos(1);

    // Same-address ordering
    yaz(32'h20, 32'd1);
    yaz(32'h20, 32'd2);
    yaz(32'h20, 32'd3);
    oku(32'h20, d);
    kontrol("sira_tampon", d, 32'd3);
    bos(12);
    kontrol("sira_bos", 32'(tampon_sayac), 32'd0);
    oku(32'h20, d);
    kontrol("sira_dizi", d, 32'd3);
    bos(1);

    // Mid-drain reset
    for (int i = 0; i < 3; i++) yaz(32'h40 + 32'(4*i), 32'hAAAA0000 + 32'(i));
    bos(15);
    for (int i = 0; i < 3; i++) yaz(32'h40 + 32'(4*i), 32'h11 * 32'(i + 1));
    kontrol("sifirla_once", 32'(tampon_sayac), 32'd3);
    #3 rst = 1'b0;
    #1 kontrol("sifirla_aninda", 32'(tampon_sayac), 32'd0);
    #7 rst = 1'b1;
    bos(1);
    for (int i = 0; i < 3; i++) begin
      oku(32'h40 + 32'(4*i), d);
      kontrol("sifirla_eski", d, 32'hAAAA0000 + 32'(i));
    end
    kontrol("sifirla_sonra", 32'(tampon_sayac), 32'd0);
    bos(1);

    // Full buffer: back-to-back stores outrun the drain
    for (int i = 0; i < 8; i++) yaz(32'h80 + 32'(4*i), 32'h100 + 32'(i));
    kontrol("dolu_bekle", 32'(bekle_goruldu), 32'd1);
    kontrol("dolu_sayac", 32'(sayac_bekle), 32'd4);
    bos(30);
    for (int i = 0; i < 8; i++) begin
      oku(32'h80 + 32'(4*i), d);
      kontrol("dolu_oku", d, 32'h100 + 32'(i));
    end
    bos(1);

    // Pointer wrap with spaced stores
    for (int i = 0; i < 12; i++) begin
      yaz(32'(4*i), 32'hC0DE0000 + 32'(i));
      bos(3);
    end
    bos(10);
    for (int i = 0; i < 12; i++) begin
      oku(32'(4*i), d);
      kontrol("sarma_oku", d, 32'hC0DE0000 + 32'(i));
    end
    kontrol("max_sayac", 32'(max_sayac), 32'd4);
    bos(1);

    // Both enables high
    vif.vb_oku_aktif = 1'b1;
    vif.vb_yaz_aktif = 1'b1;
    vif.vb_adres     = 32'h4;
    vif.vb_yaz_veri  = 32'h999;
    @(negedge clk);
`ifdef VERI_BELLEGI_HATA_EN
    kontrol("ikisi_hata", 32'(vif.vb_hata), 32'd1);
    kontrol("ikisi_oku",  vif.vb_oku_veri,  32'd0);
`else
    kontrol("ikisi_hata", 32'(vif.vb_hata), 32'd0);
    kontrol("ikisi_oku",  vif.vb_oku_veri,  32'hC0DE0001);
`endif
    bos(1);
    kontrol("ikisi_sayac", 32'(tampon_sayac), 32'd0);
    vif.vb_oku_aktif = 1'b0;
    vif.vb_yaz_aktif = 1'b0;

`ifdef VERI_BELLEGI_HATA_EN
    vif.vb_yaz_aktif = 1'b1;
    vif.vb_adres     = 32'h2;
    vif.vb_yaz_veri  = 32'h55;
    @(negedge clk);
    kontrol("hizasiz_hata", 32'(vif.vb_hata), 32'd1);
    bos(1);
    kontrol("hizasiz_sayac", 32'(tampon_sayac), 32'd0);
    vif.vb_yaz_aktif = 1'b0;
    vif.vb_oku_aktif = 1'b1;
    vif.vb_adres     = 32'h1000;
    @(negedge clk);
    kontrol("ust_hata", 32'(vif.vb_hata), 32'd1);
    kontrol("ust_oku",  vif.vb_oku_veri,  32'd0);
    vif.vb_oku_aktif = 1'b0;
`else
    vif.vb_oku_aktif = 1'b1;
    vif.vb_adres     = 32'h1000;
    @(negedge clk);
    kontrol("ust_hata", 32'(vif.vb_hata), 32'd0);
    kontrol("ust_oku",  vif.vb_oku_veri,  32'hC0DE0000);
    vif.vb_oku_aktif = 1'b0;
`endif
    bos(2);

    $display("[TB] %0d tests run, %0d failed", test_sayisi, hata_sayisi);
    $finish;
  end

endmodule
